// File: rtl/seq_stage_sequencer.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core: stage strobes, architectural PC, status, retire count.
// Optional macro SINGLE_STEP_EN adds a step input and a PAUSE state entered after every PC update.
module seq_stage_sequencer #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 15,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [63:0]      newPC,
  output logic [63:0]      PC,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [3:0]       icode_q,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXECUTE   = 4'd3;
  localparam logic [3:0] S_MEMORY    = 4'd4;
  localparam logic [3:0] S_WRITEBACK = 4'd5;
  localparam logic [3:0] S_PCUPD     = 4'd6;
  localparam logic [3:0] S_HALTED    = 4'd7;
  localparam logic [3:0] S_PAUSE     = 4'd8;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int                WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [3:0]        r_state;
  logic [63:0]       r_pc;
  logic [2:0]        r_stat;
  logic [3:0]        r_icode_q;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait;

  logic [3:0]        w_state_nxt;
  logic [2:0]        w_stat_nxt;
  logic              w_is_mem;

  // mrmovq, rmmovq, call, ret, pushq and popq touch data memory
  always_comb begin
    case (r_icode_q)
      4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: w_is_mem = 1'b1;
      default:                              w_is_mem = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stat_nxt  = r_stat;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
        else       w_state_nxt = S_IDLE;
      end
      S_FETCH: begin
        if (imem_error) begin
          w_stat_nxt  = STAT_ADR;
          w_state_nxt = S_HALTED;
        end else if (!instr_valid) begin
          w_stat_nxt  = STAT_INS;
          w_state_nxt = S_HALTED;
        end else if (icode == 4'd0) begin
          w_stat_nxt  = STAT_HLT;
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE:  w_state_nxt = S_EXECUTE;
      S_EXECUTE: w_state_nxt = w_is_mem ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (mem_ready && dmem_error) begin
          w_stat_nxt  = STAT_ADR;
          w_state_nxt = S_HALTED;
        end else if (mem_ready) begin
          w_state_nxt = S_WRITEBACK;
        end else if (r_wait == WAIT_LAST) begin
          w_stat_nxt  = STAT_ADR;
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_MEMORY;
        end
      end
      S_WRITEBACK: w_state_nxt = S_PCUPD;
`ifdef SINGLE_STEP_EN
      S_PCUPD: w_state_nxt = S_PAUSE;
      S_PAUSE: begin
        if (step) w_state_nxt = S_FETCH;
        else      w_state_nxt = S_PAUSE;
      end
`else
      S_PCUPD: w_state_nxt = S_FETCH;
`endif
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_stat    <= STAT_AOK;
      r_icode_q <= 4'd0;
      r_count   <= '0;
      r_wait    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stat  <= w_stat_nxt;
      if (r_state == S_FETCH) r_icode_q <= icode;
      if (r_state == S_PCUPD) begin
        r_pc    <= newPC;
        r_count <= r_count + CNT_W'(1);
      end
      // wait counter only runs while staying in MEMORY; any exit clears it
      if ((r_state == S_MEMORY) && (w_state_nxt == S_MEMORY)) r_wait <= r_wait + WAIT_W'(1);
      else                                                    r_wait <= '0;
    end
  end

  assign PC           = r_pc;
  assign stat         = r_stat;
  assign icode_q      = r_icode_q;
  assign instr_count  = r_count;
  assign fetch_en     = (r_state == S_FETCH);
  assign decode_en    = (r_state == S_DECODE);
  assign execute_en   = (r_state == S_EXECUTE);
  assign memory_en    = (r_state == S_MEMORY);
  assign writeback_en = (r_state == S_WRITEBACK);
  assign pc_en        = (r_state == S_PCUPD);
  assign busy         = (r_state != S_IDLE) && (r_state != S_HALTED);

endmodule

// File: doc/seq_stage_sequencer.md
Name: seq_stage_sequencer

Overview:
- Multi-cycle controller for the sequential Y86-64 core.
- Steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update by issuing one-cycle stage enables.
- Owns the architectural PC register and commits the PC-update stage result (newPC) once per instruction.
- Tracks processor status (AOK/HLT/ADR/INS), stalls on data-memory latency, retires instructions and counts them.

Parameters:
- RESET_PC, 0, PC value loaded on reset (64-bit).
- MEM_TIMEOUT, 15, maximum cycles spent in MEMORY waiting for mem_ready before ADR fault.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin execution from IDLE (level or pulse, sampled in IDLE only)
- icode  input  4  instruction code from fetch logic, valid during FETCH
- instr_valid  input  1  fetch decoded a legal icode/ifun, valid during FETCH
- imem_error  input  1  instruction address out of range, valid during FETCH
- dmem_error  input  1  data address out of range, sampled with mem_ready
- mem_ready  input  1  data memory access complete
- newPC  input  64  next PC from the PC-update logic, sampled in PCUPD
- PC  output  64  architectural PC driving fetch
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  output  1 each  stage strobes, high for exactly the cycle the FSM is in that stage
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  output  1  high in any state except IDLE and HALTED
- icode_q  output  4  icode latched at end of FETCH, held for the instruction
- instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset (async, any state, mid-instruction included): state=IDLE, PC=RESET_PC, stat=1, all strobes 0, busy=0, icode_q=0, instr_count=0, wait counter=0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED. All registered; strobes are Moore outputs of state.
- IDLE: start=1 -> FETCH next cycle; else stay.
- FETCH: icode_q<=icode. Priority: imem_error -> stat=3, HALTED; else !instr_valid -> stat=4, HALTED; else icode==0 (halt) -> stat=2, HALTED; else DECODE. PC unchanged on any fault/halt.
- DECODE -> EXECUTE unconditionally.
- EXECUTE: icode_q in {4,5,8,9,10,11} -> MEMORY; else -> WRITEBACK (memory stage skipped, memory_en never asserted).
- MEMORY: memory_en held high while waiting; wait counter increments each cycle. mem_ready=1 and dmem_error=1 -> stat=3, HALTED. mem_ready=1 and dmem_error=0 -> WRITEBACK, counter cleared. If counter reaches MEM_TIMEOUT with no mem_ready -> stat=3, HALTED. mem_ready on the first MEMORY cycle gives a single MEMORY cycle.
- WRITEBACK -> PCUPD.
- PCUPD: PC<=newPC, instr_count+=1 (wraps modulo 2^CNT_W), -> FETCH.
- Latency: non-memory instruction = 5 cycles FETCH-to-FETCH; memory instruction = 6 + (cycles until mem_ready - 1).
- HALTED: all strobes 0, busy=0, stat, PC and count held; start ignored; only rst exits.
- start while busy: ignored.

Optional Feature:
- SINGLE_STEP_EN: adds input step (1 bit) and state PAUSE. When defined, PCUPD goes to PAUSE instead of FETCH; PAUSE holds (busy=1, strobes 0) until step=1, then FETCH next cycle. start from IDLE still enters FETCH directly. When undefined: no step port, no PAUSE, PCUPD -> FETCH.

Test Plan:
- Reset with RESET_PC=0x100, start pulse, icode=6 (OPq) valid, newPC=0x102 -> strobes F,D,E,W,P on cycles 1-5, PC=0x102 after PCUPD, instr_count=1, memory_en never high.
- icode=5 (mrmovq), mem_ready delayed 3 cycles, newPC=0x10A -> memory_en high 3 cycles, 8 cycles FETCH-to-FETCH, PC=0x10A.
- icode=0 at PC=0x20 -> stat=2, HALTED after FETCH, PC stays 0x20, busy=0; subsequent start ignored.
- instr_valid=0 -> stat=4; imem_error=1 with instr_valid=0 -> stat=3 (priority); mem_ready with dmem_error=1 -> stat=3.
- mem_ready held 0 in MEMORY with MEM_TIMEOUT=15 -> HALTED with stat=3 after 15 MEMORY cycles.
- Assert rst during MEMORY -> immediate IDLE, PC=RESET_PC, stat=1, count=0; with SINGLE_STEP_EN, PAUSE after PCUPD until step=1.
